// File: rtl/sorting_hat.sv
// ============================================================================
// Module   : sorting_hat
// Purpose  : Debounced two-button house selector with a timed spin sequence
//            and a pseudo-random final pick from a free-running LFSR.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module sorting_hat #(
    parameter int          DEBOUNCE_CYCLES  = 16,
    parameter int          SPIN_STEP_CYCLES = 8,
    parameter int          SPIN_STEPS       = 12,
    parameter logic [15:0] LFSR_SEED        = 16'hACE1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_sort,
    input  logic       btn_clear,
    output logic       G,
    output logic       S,
    output logic       R,
    output logic       H,
    output logic [1:0] house,
    output logic       sorting,
    output logic       done
);

    localparam int          CW         = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int          TW         = $clog2(SPIN_STEP_CYCLES + 1);
    localparam int          SW         = $clog2(SPIN_STEPS + 1);
    localparam logic [15:0] C_SEED     = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam logic [TW-1:0] C_T_LAST = TW'(SPIN_STEP_CYCLES - 1);
    localparam logic [SW-1:0] C_S_LAST = SW'(SPIN_STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SPIN = 2'd1,
        HOLD = 2'd2
    } state_t;

    // index 0 = sort, index 1 = clear
    logic [1:0] w_raw;
    logic [1:0] r_sync1, r_sync2, r_deb, r_deb_d, r_press;

    assign w_raw = {btn_clear, btn_sort};

    for (genvar gi = 0; gi < 2; gi++) begin : g_btn
        logic [CW-1:0] r_cnt;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_sync1[gi] <= 1'b0;
                r_sync2[gi] <= 1'b0;
                r_deb[gi]   <= 1'b0;
                r_deb_d[gi] <= 1'b0;
                r_press[gi] <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_sync1[gi] <= w_raw[gi];
                r_sync2[gi] <= r_sync1[gi];
                r_deb_d[gi] <= r_deb[gi];
                r_press[gi] <= r_deb[gi] & ~r_deb_d[gi];
                if (r_sync2[gi] != r_deb[gi]) begin
                    if (r_cnt == CW'(DEBOUNCE_CYCLES)) begin
                        r_deb[gi] <= r_sync2[gi];
                        r_cnt     <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else begin
                    r_cnt <= '0;
                end
            end
        end
    end

    logic        w_sort_p, w_clear_p;
    logic [15:0] r_lfsr;

    assign w_sort_p  = r_press[0];
    assign w_clear_p = r_press[1];

    // Fibonacci taps 16,14,13,11
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lfsr <= C_SEED;
        end else begin
            r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
        end
    end

    state_t        r_state, w_state_n;
    logic [TW-1:0] r_timer, w_timer_n;
    logic [SW-1:0] r_step,  w_step_n;
    logic [1:0]    w_house_n;

    always_comb begin
        w_state_n = r_state;
        w_house_n = house;
        w_timer_n = r_timer;
        w_step_n  = r_step;
        case (r_state)
            IDLE: begin
                w_house_n = 2'b00;
                if (w_sort_p && !w_clear_p) begin
                    w_state_n = SPIN;
                    w_timer_n = '0;
                    w_step_n  = '0;
                end
            end
            SPIN: begin
                if (w_clear_p) begin
                    w_state_n = IDLE;
                    w_house_n = 2'b00;
                end else if (r_timer == C_T_LAST) begin
                    w_timer_n = '0;
                    if (r_step < C_S_LAST) begin
                        w_house_n = house + 2'd1;
                        w_step_n  = r_step + 1'b1;
                    end else begin
                        w_state_n = HOLD;
                        w_house_n = r_lfsr[1:0];
                    end
                end else begin
                    w_timer_n = r_timer + 1'b1;
                end
            end
            HOLD: begin
                if (w_clear_p) begin
                    w_state_n = IDLE;
                    w_house_n = 2'b00;
                end else if (w_sort_p) begin
                    w_state_n = SPIN;
                    w_house_n = 2'b00;
                    w_timer_n = '0;
                    w_step_n  = '0;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_house_n = 2'b00;
            end
        endcase
    end

    // Outputs are registered from the next-state values so they line up with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_timer <= '0;
            r_step  <= '0;
            house   <= 2'b00;
            G       <= 1'b0;
            S       <= 1'b0;
            R       <= 1'b0;
            H       <= 1'b0;
            sorting <= 1'b0;
            done    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_timer <= w_timer_n;
            r_step  <= w_step_n;
            house   <= w_house_n;
            G       <= (w_state_n != IDLE) && (w_house_n == 2'b00);
            S       <= (w_state_n != IDLE) && (w_house_n == 2'b01);
            R       <= (w_state_n != IDLE) && (w_house_n == 2'b10);
            H       <= (w_state_n != IDLE) && (w_house_n == 2'b11);
            sorting <= (w_state_n == SPIN);
            done    <= (r_state == SPIN) && (w_state_n == HOLD);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sorting_hat.sv
// ============================================================================
// Module   : tb_sorting_hat
// Purpose  : Directed self-checking bench for sorting_hat with default params.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_sorting_hat;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_sort = 1'b0;
    logic       btn_clear = 1'b0;
    logic       G, S, R, H;
    logic [1:0] house;
    logic       sorting, done;

    int total = 0;
    int bad   = 0;

    sorting_hat dut (
        .clk(clk), .reset(reset), .btn_sort(btn_sort), .btn_clear(btn_clear),
        .G(G), .S(S), .R(R), .H(H), .house(house), .sorting(sorting), .done(done)
    );

    always #5 clk = ~clk;

    // Reference LFSR; m_old holds the value the DUT saw before the latest edge.
    logic [15:0] m, m_old;
    always @(posedge clk) begin
        m_old <= m;
        if (reset) m <= 16'hACE1;
        else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
    end

    function automatic logic [3:0] onehot(input logic [1:0] h);
        case (h)
            2'd0:    return 4'b1000;
            2'd1:    return 4'b0100;
            2'd2:    return 4'b0010;
            default: return 4'b0001;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if ({G, S, R, H} !== 4'b0000) begin bad++; $display("FAIL reset_onehot: got %b want 0000", {G, S, R, H}); end
        total++; if (house !== 2'b00) begin bad++; $display("FAIL reset_house: got %b want 00", house); end
        total++; if (sorting !== 1'b0) begin bad++; $display("FAIL reset_sorting: got %b want 0", sorting); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        reset = 1'b0;
    endtask

    task automatic test_glitch();
        logic seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            btn_sort = (c < 10);
            tick();
            seen |= sorting | done | (|{G, S, R, H}) | (|house);
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL glitch_activity: got %b want 0", seen); end
    endtask

    // Holds sort for hold_cycles; press pulse at edge 19, SPIN visible after edge 20.
    task automatic test_full_sort(input int hold_cycles, input string tag);
        logic       spin_err = 1'b0;
        logic [1:0] eh;
        for (int c = 0; c <= 117; c++) begin
            btn_sort = (c < hold_cycles);
            tick();
            if (c == 19) begin
                total++; if (sorting !== 1'b0) begin bad++; $display("FAIL %s_early: sorting got %b want 0", tag, sorting); end
            end
            if (c >= 20 && c <= 115) begin
                if (sorting !== 1'b1 || done !== 1'b0) spin_err = 1'b1;
                if ((c - 20) % 8 == 0) begin
                    eh = 2'(((c - 20) / 8) % 4);
                    total++; if (house !== eh || {G, S, R, H} !== onehot(eh)) begin
                        bad++; $display("FAIL %s_step%0d: got house=%b ghsr=%b want house=%b ghsr=%b",
                                        tag, (c - 20) / 8, house, {G, S, R, H}, eh, onehot(eh));
                    end
                end
            end
            if (c == 116) begin
                total++; if (done !== 1'b1 || sorting !== 1'b0) begin bad++; $display("FAIL %s_done: got done=%b sorting=%b want 1 0", tag, done, sorting); end
                total++; if (house !== m_old[1:0] || {G, S, R, H} !== onehot(m_old[1:0])) begin
                    bad++; $display("FAIL %s_final: got house=%b ghsr=%b want house=%b ghsr=%b",
                                    tag, house, {G, S, R, H}, m_old[1:0], onehot(m_old[1:0]));
                end
            end
            if (c == 117) begin
                total++; if (done !== 1'b0) begin bad++; $display("FAIL %s_done_width: got %b want 0", tag, done); end
            end
        end
        total++; if (spin_err !== 1'b0) begin bad++; $display("FAIL %s_spin_level: got err=%b want 0", tag, spin_err); end
    endtask

    task automatic test_simultaneous();
        logic seen = 1'b0;
        for (int c = 0; c < 60; c++) begin
            btn_sort  = (c < 20);
            btn_clear = (c < 20);
            tick();
            if (c == 19) begin
                total++; if ({G, S, R, H} !== onehot(house)) begin bad++; $display("FAIL simul_pre_hold: got %b want %b", {G, S, R, H}, onehot(house)); end
            end
            if (c == 20) begin
                total++; if ({G, S, R, H, house, sorting} !== 7'b0) begin bad++; $display("FAIL simul_clear_wins: got %b want 0000000", {G, S, R, H, house, sorting}); end
            end
            if (c >= 20) seen |= sorting | done;
        end
        total++; if (seen !== 1'b0) begin bad++; $display("FAIL simul_no_spin: got %b want 0", seen); end
    endtask

    task automatic test_clear_mid_spin();
        logic seen_done = 1'b0;
        logic seen_spin = 1'b0;
        for (int c = 0; c < 140; c++) begin
            btn_sort  = (c < 20);
            btn_clear = (c >= 43 && c < 63);
            tick();
            seen_done |= done;
            if (c == 62) begin
                total++; if (sorting !== 1'b1 || house !== 2'b01) begin bad++; $display("FAIL clear_pre: got sorting=%b house=%b want 1 01", sorting, house); end
            end
            if (c == 63) begin
                total++; if ({G, S, R, H, house, sorting} !== 7'b0) begin bad++; $display("FAIL clear_idle: got %b want 0000000", {G, S, R, H, house, sorting}); end
            end
            if (c > 63) seen_spin |= sorting;
        end
        total++; if (seen_done !== 1'b0) begin bad++; $display("FAIL clear_no_done: got %b want 0", seen_done); end
        total++; if (seen_spin !== 1'b0) begin bad++; $display("FAIL clear_stays_idle: got %b want 0", seen_spin); end
    endtask

    task automatic test_reset_mid_spin();
        for (int c = 0; c < 46; c++) begin
            btn_sort = (c < 20);
            tick();
            if (c == 44) begin
                total++; if (sorting !== 1'b1 || house !== 2'b11) begin bad++; $display("FAIL rst_pre: got sorting=%b house=%b want 1 11", sorting, house); end
            end
        end
        reset = 1'b1;
        tick();
        total++; if ({G, S, R, H, house, sorting, done} !== 8'b0) begin bad++; $display("FAIL rst_mid: got %b want 00000000", {G, S, R, H, house, sorting, done}); end
        reset = 1'b0;
        test_full_sort(20, "after_rst");
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_full_sort(40, "full");
        test_full_sort(20, "resort");
        test_simultaneous();
        test_clear_mid_spin();
        test_reset_mid_spin();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
